// File: rtl/frame_sequencer.sv
// Capture/inference sequencer for the RPS classifier.
// Clears the Pi image receiver, tells the Pi to send a frame, latches the hand
// mask once the receiver reports it complete, runs one inference on it and
// publishes a debounced gesture after a run of identical classifications.
module frame_sequencer #(
    parameter int LENGTH        = 28,
    parameter int WIDTH         = 28,
    parameter int CLEAR_CYCLES  = 4096,
    parameter int FRAME_TIMEOUT = 50000000,
    parameter int NN_TIMEOUT    = 65535,
    parameter int STABLE_FRAMES = 3
) (
    input  logic                      fpga_clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      rx_image_ready,
    input  logic [LENGTH*WIDTH-1:0]   rx_image,
    output logic                      rx_clear,
    output logic                      pi_ready,
    output logic [LENGTH*WIDTH-1:0]   nn_image,
    output logic                      nn_start,
    input  logic                      nn_done,
    input  logic [1:0]                nn_class,
    output logic [1:0]                gesture,
    output logic                      gesture_valid,
    output logic [15:0]               frame_count,
    output logic                      timeout_err
);

    localparam int          IMG_W      = LENGTH * WIDTH;
    localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_CYCLES - 1);
    localparam logic [31:0] FRAME_LAST = 32'(FRAME_TIMEOUT - 1);
    localparam logic [31:0] NN_LAST    = 32'(NN_TIMEOUT - 1);
    localparam logic [3:0]  STABLE_N   = 4'(STABLE_FRAMES);
    localparam logic [1:0]  CLASS_NONE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_FRAME,
        S_LATCH,
        S_START,
        S_INFER_WAIT,
        S_UPDATE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_timer;
    logic               r_rdy_meta;
    logic               r_rdy_s;
    logic [IMG_W-1:0]   r_nn_image;
    logic [1:0]         r_class;
    logic [1:0]         r_last_class;
    logic [3:0]         r_run_len;
    logic [1:0]         r_gesture;
    logic               r_gesture_valid;
    logic [15:0]        r_frame_count;
    logic               r_timeout_err;

    logic               w_rx_clear;
    logic               w_pi_ready;
    logic               w_nn_start;
    logic               w_latch;
    logic               w_capture;
    logic               w_update;
    logic               w_set_timeout;
    logic [3:0]         w_run_next;
    logic               w_publish;

    // Run length saturates so a long steady gesture cannot wrap back below the threshold.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Two-flop synchronizer for the receiver's frame-complete level.
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            r_rdy_meta <= 1'b0;
            r_rdy_s    <= 1'b0;
        end else begin
            r_rdy_meta <= rx_image_ready;
            r_rdy_s    <= r_rdy_meta;
        end
    end

    // State register and shared timer; the timer restarts from zero whenever the state changes.
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= 32'd0;
        end else begin
            r_state <= w_next;
            r_timer <= (w_next != r_state) ? 32'd0 : r_timer + 32'd1;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_next        = r_state;
        w_rx_clear    = 1'b0;
        w_pi_ready    = 1'b0;
        w_nn_start    = 1'b0;
        w_latch       = 1'b0;
        w_capture     = 1'b0;
        w_update      = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_rx_clear = 1'b1;
                if (r_timer == CLEAR_LAST) w_next = S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                w_pi_ready = 1'b1;
                if (!enable) begin
                    w_next = S_IDLE;
                end else if (r_rdy_s) begin
                    w_next = S_LATCH;
                end else if (r_timer == FRAME_LAST) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_CLEAR;
                end
            end
            S_LATCH: begin
                w_latch = 1'b1;
                w_next  = S_START;
            end
            S_START: begin
                // nn_done is deliberately not looked at here: a level left over
                // from the previous inference must not complete this one.
                w_nn_start = 1'b1;
                w_next     = S_INFER_WAIT;
            end
            S_INFER_WAIT: begin
                if (nn_done) begin
                    w_capture = 1'b1;
                    w_next    = S_UPDATE;
                end else if (r_timer == NN_LAST) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_CLEAR;
                end
            end
            S_UPDATE: begin
                w_update = 1'b1;
                w_next   = enable ? S_CLEAR : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_run_next = (r_class == r_last_class) ? sat_inc4(r_run_len) : 4'd1;
    assign w_publish  = (w_run_next >= STABLE_N);

    // Frame latch, class capture, debounce and status registers.
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            r_nn_image      <= '0;
            r_class         <= 2'd0;
            r_last_class    <= 2'd0;
            r_run_len       <= 4'd0;
            r_gesture       <= 2'd0;
            r_gesture_valid <= 1'b0;
            r_frame_count   <= 16'd0;
            r_timeout_err   <= 1'b0;
        end else begin
            if (w_latch) r_nn_image <= rx_image;
            if (w_capture) r_class <= nn_class;
            if (w_set_timeout) r_timeout_err <= 1'b1;
            if (w_update) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_run_len     <= w_run_next;
                r_last_class  <= r_class;
                if (w_publish) begin
                    // A stable "none" withdraws the gesture but keeps the last value visible.
                    if (r_class == CLASS_NONE) begin
                        r_gesture_valid <= 1'b0;
                    end else begin
                        r_gesture       <= r_class;
                        r_gesture_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign rx_clear      = w_rx_clear;
    assign pi_ready      = w_pi_ready;
    assign nn_start      = w_nn_start;
    assign nn_image      = r_nn_image;
    assign gesture       = r_gesture;
    assign gesture_valid = r_gesture_valid;
    assign frame_count   = r_frame_count;
    assign timeout_err   = r_timeout_err;

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Top-level capture/inference controller for the RPS classifier; runs on fpga_clk.
- Repeatedly resets the Pi image receiver and signals the Pi to transmit a frame.
- Waits for the receiver's image-ready flag, latches the binary hand mask, and runs one neural-net inference on it.
- Publishes a debounced gesture once the same class is seen on STABLE_FRAMES consecutive frames.

Parameters:
- LENGTH, 28, image rows.
- WIDTH, 28, image columns.
- CLEAR_CYCLES, 4096, fpga_clk cycles rx_clear is held high. Must exceed 2x the receiver's slow-clock period so its debounced reset is seen.
- FRAME_TIMEOUT, 50000000, max cycles in WAIT_FRAME (1 s at 50 MHz).
- NN_TIMEOUT, 65535, max cycles in INFER_WAIT.
- STABLE_FRAMES, 3, consecutive identical classes required to publish (range 1..15).

Ports:
- fpga_clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, run continuously while high.
- rx_image_ready, in, 1, receiver frame-complete level. Asynchronous to fpga_clk; synchronized internally.
- rx_image, in, LENGTH*WIDTH, receiver mask. Row r, column c is at bit r*WIDTH+c. Stable while rx_image_ready is high.
- rx_clear, out, 1, reset to the receiver.
- pi_ready, out, 1, tells the Pi it may send a frame.
- nn_image, out, LENGTH*WIDTH, latched mask for the classifier.
- nn_start, out, 1, one-cycle inference start pulse.
- nn_done, in, 1, classifier done pulse or level.
- nn_class, in, 2, classifier result, valid with nn_done: 0 rock, 1 paper, 2 scissors, 3 none.
- gesture, out, 2, published class.
- gesture_valid, out, 1, gesture is meaningful.
- frame_count, out, 16, completed inferences, wraps.
- timeout_err, out, 1, sticky timeout flag; cleared only by rst.

Behaviour:
- Reset (synchronous, rst high at a fpga_clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including nn_image, gesture and frame_count.
  - The 2-flop synchronizer, timers, last_class and run_len are cleared.
  - Reset mid-operation aborts any state immediately; no partial update of the debounce state.
- Synchronizer: rdy_s is rx_image_ready through two flops. A rising input is visible to the FSM 2 cycles later.
- One shared 32-bit timer; it is zeroed on every state entry.
- FSM (states, outputs, transitions):
  - IDLE: outputs low.
    - enable=1: go to CLEAR.
  - CLEAR: rx_clear=1.
    - When timer==CLEAR_CYCLES-1: go to WAIT_FRAME.
    - rx_clear is high for exactly CLEAR_CYCLES cycles.
  - WAIT_FRAME: pi_ready=1. Checks in priority order:
    1. enable=0: go to IDLE.
    2. rdy_s=1: go to LATCH.
    3. timer==FRAME_TIMEOUT-1: set timeout_err, go to CLEAR.
  - LATCH: nn_image <= rx_image; pi_ready=0; go to START.
  - START: nn_start=1 for this single cycle; go to INFER_WAIT.
    - nn_done is ignored in START.
  - INFER_WAIT:
    - nn_done=1: capture nn_class, go to UPDATE.
    - Otherwise, timer==NN_TIMEOUT-1: set timeout_err, go to CLEAR. The frame is discarded; frame_count and debounce state are unchanged.
    - nn_done and timeout in the same cycle: nn_done wins.
  - UPDATE:
    - frame_count increments, 16'hFFFF wraps to 0.
    - If class==last_class, run_len increments, saturating at 15. Otherwise run_len=1 and last_class=class.
    - Publish condition: new run_len>=STABLE_FRAMES.
      - Class 0..2: gesture<=class, gesture_valid<=1.
      - Class 3: gesture_valid<=0, gesture holds.
    - Not stable: gesture and gesture_valid hold.
    - Next state: CLEAR if enable=1, else IDLE.
- enable falling outside WAIT_FRAME and UPDATE does not abort the current frame.
- gesture and gesture_valid persist across IDLE.
- Latency: rx_image_ready rising in WAIT_FRAME gives nn_start high 4 cycles later (sync 2, LATCH 1, START 1).
- nn_image changes only in LATCH.

Test Plan:
Sim parameters: CLEAR_CYCLES=8, FRAME_TIMEOUT=100, NN_TIMEOUT=20, STABLE_FRAMES=3.
1. rst, then enable=1 -> rx_clear high exactly 8 cycles, then pi_ready=1.
2. Raise rx_image_ready with rx_image=pattern A -> pi_ready drops, nn_start pulses 4 cycles after the rise for one cycle, nn_image==A.
3. nn_done pulses with class 1 on three consecutive frames:
   - After frames 1 and 2: gesture_valid=0.
   - After frame 3: gesture=1, gesture_valid=1, frame_count=3.
   - A fourth frame of class 2 leaves gesture=1.
4. Never raise rx_image_ready -> after 100 cycles in WAIT_FRAME, timeout_err=1, rx_clear re-asserts for 8 cycles.
5. Never assert nn_done -> after 20 cycles, timeout_err=1, frame_count unchanged. Also assert nn_done exactly on the timeout cycle -> UPDATE is taken.
6. Assert rst mid-INFER_WAIT -> next cycle all outputs 0, state IDLE. Also check enable=0 in WAIT_FRAME gives IDLE with pi_ready=0, and frame_count wraps at 16'hFFFF to 0.
